// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Purpose:
//   Scans a 4x4 active-low matrix keypad. One row is driven low at a time and
//   rotates on every scan tick while no key is seen. A candidate key is
//   debounced over DEB_TICKS consecutive scan-tick samples before it is
//   accepted. A release is debounced the same way before the key is dropped.
//
// Parameters:
//   SCAN_DIV   clk cycles per scan tick (2 .. 2**20)
//   DEB_TICKS  consecutive matching tick samples to accept press/release (1..15)
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   col[3:0]   keypad column lines, active-low, pulled up externally
//   row[3:0]   keypad row drive, active-low, exactly one bit low
//   onehot     held key as a one-hot vector (row*4 + col), 0 = no key
//   key_code   binary index of the last accepted key, kept after release
//   key_valid  one-cycle pulse when a press is accepted
//
// Build option:
//   KEYPAD_GHOST_REJECT_EN  when defined, a sample with two or more columns
//                           low on the driven row counts as "no key" while
//                           scanning and as a mismatch while debouncing a
//                           press. When undefined, the lowest low column wins.
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned DEB_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] onehot,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS);
    localparam logic [3:0] ROW_FIRST = 4'b1110;

    typedef enum logic [1:0] {
        ST_SCAN        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Decode the active-low column sample into {hit, column index}.
    function automatic logic [2:0] decode_cols(input logic [3:0] col_low);
        logic [2:0] res;
        res = 3'b000;
`ifdef KEYPAD_GHOST_REJECT_EN
        // Only a single low column is a usable key; anything else is ghosting.
        case (col_low)
            4'b0001: res = 3'b100;
            4'b0010: res = 3'b101;
            4'b0100: res = 3'b110;
            4'b1000: res = 3'b111;
            default: res = 3'b000;
        endcase
`else
        // Lowest-numbered low column wins.
        if (col_low[0]) begin
            res = 3'b100;
        end else if (col_low[1]) begin
            res = 3'b101;
        end else if (col_low[2]) begin
            res = 3'b110;
        end else if (col_low[3]) begin
            res = 3'b111;
        end else begin
            res = 3'b000;
        end
`endif
        return res;
    endfunction

    // Row index of the currently driven (low) row.
    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        case (r)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Next row pattern; any corrupted pattern recovers to the first row.
    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        logic [3:0] nxt;
        case (r)
            4'b1110: nxt = 4'b1101;
            4'b1101: nxt = 4'b1011;
            4'b1011: nxt = 4'b0111;
            4'b0111: nxt = 4'b1110;
            default: nxt = ROW_FIRST;
        endcase
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [3:0]       col_meta_q;
    logic [3:0]       col_sync_q;
    logic [DIV_W-1:0] div_q;
    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       key_row_q, key_row_d;
    logic [1:0]       key_col_q, key_col_d;
    logic [15:0]      onehot_q, onehot_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;

    // -------------------------------------------------------------------------
    // Derived combinational signals
    // -------------------------------------------------------------------------
    logic             tick_s;
    logic [2:0]       dec_s;
    logic             hit_s;
    logic [1:0]       hit_col_s;
    logic [1:0]       cur_row_s;
    logic             match_s;
    logic             key_up_s;
    logic [3:0]       cnt_inc_s;
    logic             cnt_done_s;

    assign tick_s     = (div_q == DIV_LAST);
    assign dec_s      = decode_cols(~col_sync_q);
    assign hit_s      = dec_s[2];
    assign hit_col_s  = dec_s[1:0];
    assign cur_row_s  = row_index(row_q);
    // Row is frozen while debouncing, so only the column needs comparing.
    assign match_s    = hit_s && (hit_col_s == key_col_q);
    assign key_up_s   = col_sync_q[key_col_q];
    // Saturating increment: never wraps past DEB_TICKS.
    assign cnt_inc_s  = (cnt_q >= DEB_LAST) ? DEB_LAST : (cnt_q + 4'd1);
    assign cnt_done_s = (cnt_inc_s == DEB_LAST);

    // Column synchronizer and free-running scan-tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
            div_q      <= '0;
        end else begin
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
            if (div_q >= DIV_LAST) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; all decisions happen on scan ticks.
    always_comb begin
        state_d = state_q;
        if (tick_s) begin
            case (state_q)
                ST_SCAN: begin
                    if (hit_s) begin
                        state_d = ST_DEB_PRESS;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!match_s) begin
                        state_d = ST_SCAN;
                    end else if (cnt_done_s) begin
                        state_d = ST_PRESSED;
                    end else begin
                        state_d = ST_DEB_PRESS;
                    end
                end
                ST_PRESSED: begin
                    // Other columns going low are ignored while a key is held.
                    if (key_up_s) begin
                        state_d = ST_DEB_RELEASE;
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_DEB_RELEASE: begin
                    if (!key_up_s) begin
                        state_d = ST_PRESSED;
                    end else if (cnt_done_s) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_DEB_RELEASE;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM output logic: next values for the row drive, debounce counter,
    // latched key and the registered key outputs.
    always_comb begin
        row_d       = row_q;
        cnt_d       = cnt_q;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        onehot_d    = onehot_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (!tick_s) begin
                    cnt_d = cnt_q;
                end else if (hit_s) begin
                    // Freeze the row and latch the candidate key.
                    key_row_d = cur_row_s;
                    key_col_d = hit_col_s;
                    cnt_d     = 4'd0;
                end else begin
                    row_d = rotate_row(row_q);
                    cnt_d = 4'd0;
                end
            end
            ST_DEB_PRESS: begin
                if (!tick_s) begin
                    cnt_d = cnt_q;
                end else if (!match_s) begin
                    cnt_d = 4'd0;
                end else if (cnt_done_s) begin
                    // Acceptance: onehot, key_code and key_valid move together.
                    cnt_d       = cnt_inc_s;
                    onehot_d    = 16'h0001 << {key_row_q, key_col_q};
                    key_code_d  = {key_row_q, key_col_q};
                    key_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_PRESSED: begin
                if (tick_s && key_up_s) begin
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DEB_RELEASE: begin
                if (!tick_s) begin
                    cnt_d = cnt_q;
                end else if (!key_up_s) begin
                    cnt_d = 4'd0;
                end else if (cnt_done_s) begin
                    cnt_d    = cnt_inc_s;
                    onehot_d = 16'h0000;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                row_d    = ROW_FIRST;
                cnt_d    = 4'd0;
                onehot_d = 16'h0000;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= ROW_FIRST;
            cnt_q       <= 4'd0;
            key_row_q   <= 2'd0;
            key_col_q   <= 2'd0;
            onehot_q    <= 16'h0000;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            onehot_q    <= onehot_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign row       = row_q;
    assign onehot    = onehot_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//
// Self-checking bench for keypad_scan (SCAN_DIV=4, DEB_TICKS=2). A keypad model
// pulls columns low for held keys on the driven row. A tick-level reference
// model tracks the scanned row, the candidate key and its run length, and the
// held key, and predicts every output on every clock.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] onehot;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] keys = 16'h0000;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Reference model state
    int          m_row;
    int          m_cand;
    int          m_held;
    int          m_run;
    int          m_rel;
    int          m_div;
    logic [3:0]  m_meta;
    logic [3:0]  m_sync;
    logic [15:0] exp_onehot;
    logic [3:0]  exp_code;
    logic        exp_valid;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV(SD), .DEB_TICKS(DT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .onehot    (onehot),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    // Physical keypad: a held key shorts its row to its column.
    function automatic logic [3:0] pad_cols(input logic [3:0] r, input logic [15:0] k);
        logic [3:0] res;
        res = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            if (!r[ri])
                for (int ci = 0; ci < 4; ci++)
                    if (k[ri*4+ci]) res[ci] = 1'b0;
        return res;
    endfunction

    assign col = pad_cols(row, keys);

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] p;
        p = 4'hF;
        p[r] = 1'b0;
        return p;
    endfunction

    // Column seen in a sample, or -1 for "no key".
    function automatic int seen_col(input logic [3:0] s);
        int n;
        int c;
        n = 0;
        c = -1;
        for (int i = 3; i >= 0; i--)
            if (!s[i]) begin
                n++;
                c = i;
            end
`ifdef KEYPAD_GHOST_REJECT_EN
        if (n > 1) c = -1;
`endif
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_cand = -1; m_held = -1; m_run = 0; m_rel = 0; m_div = 0;
        m_meta = 4'hF; m_sync = 4'hF;
        exp_onehot = 16'h0000; exp_code = 4'h0; exp_valid = 1'b0;
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step();
        logic [3:0] now_col;
        logic [3:0] s;
        int c;
        int seen;
        now_col = pad_cols(row_pat(m_row), keys);
        s = m_sync;
        exp_valid = 1'b0;
        if (m_div == SD - 1) begin
            c = seen_col(s);
            seen = (c >= 0) ? (m_row * 4 + c) : -1;
            if (m_held < 0) begin
                if (m_cand < 0) begin
                    if (seen >= 0) begin
                        m_cand = seen;
                        m_run = 0;
                    end else begin
                        m_row = (m_row + 1) % 4;
                    end
                end else if (seen == m_cand) begin
                    m_run++;
                    if (m_run == DT) begin
                        m_held = m_cand;
                        m_cand = -1;
                        exp_valid = 1'b1;
                        exp_onehot = 16'h0001 << m_held;
                        exp_code = 4'(m_held);
                    end
                end else begin
                    m_cand = -1;
                    m_run = 0;
                end
            end else begin
                if (m_rel == 0) begin
                    if (s[m_held % 4]) begin
                        m_rel = 1;
                        m_run = 0;
                    end
                end else if (s[m_held % 4]) begin
                    m_run++;
                    if (m_run == DT) begin
                        m_held = -1;
                        m_rel = 0;
                        exp_onehot = 16'h0000;
                    end
                end else begin
                    m_rel = 0;
                    m_run = 0;
                end
            end
        end
        m_div = (m_div + 1) % SD;
        m_sync = m_meta;
        m_meta = now_col;
    endtask

    // One clock: predict, let the edge happen, compare at the falling edge.
    task automatic cycle();
        model_step();
        @(negedge clk);
        if (key_valid === 1'b1) pulses++;
        check_eq("row", row, row_pat(m_row));
        check_eq("onehot", onehot, exp_onehot);
        check_eq("key_code", key_code, exp_code);
        check_eq("key_valid", key_valid, exp_valid);
        check_eq("row_one_low", $countones(~row), 1);
        check_eq("onehot_le1", ($countones(onehot) <= 1), 1);
    endtask

    task automatic run_ticks(input int n);
        repeat (n * SD) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_row"}, row, 4'b1110);
        check_eq({tag, "_onehot"}, onehot, 16'h0000);
        check_eq({tag, "_code"}, key_code, 4'h0);
        check_eq({tag, "_valid"}, key_valid, 1'b0);
    endtask

    initial begin
        int p0;
        logic [15:0] g_onehot;
        int g_pulses;
        logic [3:0] rows_seen;
        int n;

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single key 6 (row 1, column 2)
        keys = 16'h0040;
        p0 = pulses;
        run_ticks(16);
        check_eq("k6_pulses", pulses - p0, 1);
        check_eq("k6_onehot", onehot, 16'h0040);
        check_eq("k6_code", key_code, 4'h6);
        keys = 16'h0000;
        run_ticks(8);
        check_eq("k6_released", onehot, 16'h0000);
        check_eq("k6_code_kept", key_code, 4'h6);

        // Bouncing key 11, then stable, then a one-tick release glitch
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0800;
            run_ticks(1);
            keys = 16'h0000;
            run_ticks(1);
        end
        check_eq("bounce_no_pulse", pulses - p0, 0);
        keys = 16'h0800;
        run_ticks(16);
        check_eq("bounce_one_pulse", pulses - p0, 1);
        p0 = pulses;
        keys = 16'h0000;
        run_ticks(1);
        keys = 16'h0800;
        run_ticks(6);
        check_eq("glitch_onehot", onehot, 16'h0800);
        check_eq("glitch_no_pulse", pulses - p0, 0);
        keys = 16'h0000;
        run_ticks(8);

        // Two columns low on row 0
`ifdef KEYPAD_GHOST_REJECT_EN
        g_onehot = 16'h0000;
        g_pulses = 0;
`else
        g_onehot = 16'h0001;
        g_pulses = 1;
`endif
        p0 = pulses;
        keys = 16'h0003;
        run_ticks(16);
        check_eq("ghost_onehot", onehot, g_onehot);
        check_eq("ghost_pulses", pulses - p0, g_pulses);
        keys = 16'h0000;
        run_ticks(8);

        // Reset while key 9 is held
        keys = 16'h0200;
        n = 0;
        while (onehot !== 16'h0200 && n < 400) begin
            cycle();
            n++;
        end
        check_eq("rst_key_held", onehot, 16'h0200);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        p0 = pulses;
        run_ticks(16);
        check_eq("rst_redetect_pulse", pulses - p0, 1);
        check_eq("rst_redetect_code", key_code, 4'h9);
        keys = 16'h0000;
        run_ticks(8);

        // Idle scanning
        p0 = pulses;
        rows_seen = 4'h0;
        for (int i = 0; i < 100 * SD; i++) begin
            cycle();
            rows_seen = rows_seen | ~row;
        end
        check_eq("idle_rows", rows_seen, 4'hF);
        check_eq("idle_pulses", pulses - p0, 0);

        // Random presses, multi-key chords, glitches and uneven hold times
        for (int it = 0; it < 30; it++) begin
            keys = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) keys = keys | (16'h0001 << $urandom_range(0, 15));
            for (int seg = 0; seg < 4; seg++) begin
                repeat ($urandom_range(1, 6 * SD)) cycle();
                if ($urandom_range(0, 4) == 0) begin
                    logic [15:0] held;
                    held = keys;
                    keys = 16'h0000;
                    repeat ($urandom_range(1, 2 * SD)) cycle();
                    keys = held;
                end
            end
            keys = 16'h0000;
            repeat ($urandom_range(1, 12 * SD)) cycle();
        end
        keys = 16'h0000;
        run_ticks(10);
        check_eq("final_idle", onehot, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
